// File: rtl/bus_arbiter_pkg.sv
// Shared types for the memory-bus arbiter slice.
//   word_t      : 32-bit bus address / data word
//   wstrobe_t   : per-byte write strobes, all-zero means read
//   arb_state_t : arbiter FSM state
package bus_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam word_t DEFAULT_ERROR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: given a request vector and the index of the last owner,
// returns the next owner scanning last+1, last+2, ... modulo N.
//   req_i    : request vector
//   last_i   : index of the previous owner
//   onehot_o : one-hot of the chosen requester (zero when none)
//   idx_o    : index of the chosen requester (zero when none)
//   any_o    : at least one request present
module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        // k runs 1..N so the last owner is considered only after everyone else.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to 1-slave valid/ready bus arbiter with round-robin grant, a single
// outstanding transaction and an optional slave timeout that answers the
// master with ERROR_WORD.
//   clk, reset (async, active-low)
//   m_valid/m_ready/m_address/m_wstrobe/m_wdata/m_rdata : per-master channel
//   m_irq         : broadcast copy of s_irq
//   s_valid/s_ready/s_address/s_wstrobe/s_wdata/s_rdata : slave channel
//   s_irq         : slave interrupt
//   grant         : index of the current or last owner
//   timeout       : one-cycle pulse when a transaction is aborted
//   timeout_count : saturating number of aborts
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int    N_MASTERS      = 2,
    parameter  int    TIMEOUT_CYCLES = 0,
    parameter  word_t ERROR_WORD     = DEFAULT_ERROR_WORD,
    localparam int    GW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MASTERS-1:0]    m_valid,
    output logic [N_MASTERS-1:0]    m_ready,
    input  word_t [N_MASTERS-1:0]   m_address,
    input  wstrobe_t [N_MASTERS-1:0] m_wstrobe,
    input  word_t [N_MASTERS-1:0]   m_wdata,
    output word_t [N_MASTERS-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]    m_irq,
    output logic                    s_valid,
    input  logic                    s_ready,
    output word_t                   s_address,
    output wstrobe_t                s_wstrobe,
    output word_t                   s_wdata,
    input  word_t                   s_rdata,
    input  logic                    s_irq,
    output logic [GW-1:0]           grant,
    output logic                    timeout,
    output logic [7:0]              timeout_count
);

    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMER_LIMIT = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    arb_state_t             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [N_MASTERS-1:0]   owner_q, owner_d;
    logic [31:0]            timer_q, timer_d;
    logic [7:0]             tocnt_q, tocnt_d;

    logic [N_MASTERS-1:0]   pick_onehot;
    logic [GW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   done;
    word_t                  done_data;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req_i    (m_valid),
        .last_i   (last_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_MASTERS - 1);
            owner_q <= '0;
            timer_q <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            tocnt_q <= tocnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        tocnt_d   = tocnt_q;
        s_valid   = 1'b0;
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        done      = 1'b0;
        done_data = '0;
        timeout   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // s_ready is deliberately not looked at here: a late
                // completion after an abort must not reach any master.
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    owner_d = pick_onehot;
                    timer_d = '0;
                end
            end
            ARB_BUSY: begin
                s_valid   = |(m_valid & owner_q);
                s_address = m_address[grant_q];
                s_wstrobe = m_wstrobe[grant_q];
                s_wdata   = m_wdata[grant_q];
                if (!s_valid) begin
                    // Owner withdrew its request: drop it silently.
                    state_d = ARB_IDLE;
                    timer_d = '0;
                end else if (s_ready) begin
                    // Completion has priority over a coincident expiry.
                    done      = 1'b1;
                    done_data = s_rdata;
                    state_d   = ARB_IDLE;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LIMIT)) begin
                    done      = 1'b1;
                    done_data = ERROR_WORD;
                    timeout   = 1'b1;
                    state_d   = ARB_IDLE;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (done && owner_q[i]) begin
                m_ready[i] = 1'b1;
                m_rdata[i] = done_data;
            end
        end
    end

    assign m_irq         = {N_MASTERS{s_irq}};
    assign grant         = grant_q;
    assign timeout_count = tocnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int N = 3;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [N-1:0]       m_valid;
    logic [N-1:0]       m_ready;
    logic [N-1:0][31:0] m_address;
    logic [N-1:0][3:0]  m_wstrobe;
    logic [N-1:0][31:0] m_wdata;
    logic [N-1:0][31:0] m_rdata;
    logic [N-1:0]       m_irq;
    logic               s_valid;
    logic               s_ready;
    logic [31:0]        s_address;
    logic [3:0]         s_wstrobe;
    logic [31:0]        s_wdata;
    logic [31:0]        s_rdata;
    logic [31:0]        s_rdata_val;
    logic               echo;
    logic               s_irq;
    logic [1:0]         grant;
    logic               timeout;
    logic [7:0]         timeout_count;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(4), .ERROR_WORD(32'hDEAD_BEEF)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_address     (m_address),
        .m_wstrobe     (m_wstrobe),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_irq         (m_irq),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_address     (s_address),
        .s_wstrobe     (s_wstrobe),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_irq         (s_irq),
        .grant         (grant),
        .timeout       (timeout),
        .timeout_count (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave data: either an address-derived echo or an explicit value.
    always_comb s_rdata = echo ? (s_address ^ 32'hFFFF_0000) : s_rdata_val;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Completion monitor: every m_ready pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset && (m_ready != '0)) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'(m_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_owner", 32'(m_ready), 32'(3'b001 << e.idx));
                check_val("sb_rdata", m_rdata[e.idx], e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset       = 1'b0;
        m_valid     = '0;
        m_address   = '0;
        m_wstrobe   = '0;
        m_wdata     = '0;
        s_ready     = 1'b0;
        s_rdata_val = '0;
        echo        = 1'b0;
        s_irq       = 1'b0;

        // Reset holds everything even with requests present.
        repeat (2) step();
        m_valid = 3'b111;
        step();
        #1;
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_svalid", 32'(s_valid), 32'd0);
        check_val("rst_mready", 32'(m_ready), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_tocnt", 32'(timeout_count), 32'd0);
        m_valid = '0;
        reset   = 1'b1;
        step();

        // Single read from master 0, slave ready on 2nd BUSY cycle.
        m_address[0] = 32'h0000_0100;
        m_valid      = 3'b001;
        push(0, 32'h0000_1234);
        #1;
        check_val("single_idle_svalid", 32'(s_valid), 32'd0);
        step();
        #1;
        check_val("single_svalid", 32'(s_valid), 32'd1);
        check_val("single_grant", 32'(grant), 32'd0);
        check_val("single_addr", s_address, 32'h0000_0100);
        check_val("single_wstrb", 32'(s_wstrobe), 32'd0);
        check_val("single_wait_mready", 32'(m_ready), 32'd0);
        step();
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_1234;
        #1;
        check_val("single_mready", 32'(m_ready), 32'b001);
        step();
        m_valid = '0;
        s_ready = 1'b0;
        #1;
        check_val("single_done_svalid", 32'(s_valid), 32'd0);

        // Fairness from a fresh reset: all request, slave always ready.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        echo = 1'b1;
        for (int i = 0; i < N; i++) m_address[i] = 32'(i + 1) << 12;
        for (int t = 0; t < 6; t++) push(t % 3, (32'((t % 3) + 1) << 12) ^ 32'hFFFF_0000);
        s_ready = 1'b1;
        m_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            step();
            #1;
            check_val("fair_grant", 32'(grant), 32'(t % 3));
            check_val("fair_mready", 32'(m_ready), 32'(3'b001 << (t % 3)));
            step();
            if (t == 5) m_valid = '0;
            #1;
            check_val("fair_gap", 32'(m_ready), 32'd0);
        end
        s_ready = 1'b0;
        echo    = 1'b0;

        // Write forwarding from master 1.
        m_address[1] = 32'h0000_2000;
        m_wstrobe[1] = 4'b0011;
        m_wdata[1]   = 32'hAABB_CCDD;
        m_valid      = 3'b010;
        step();
        #1;
        check_val("wr_grant", 32'(grant), 32'd1);
        check_val("wr_svalid", 32'(s_valid), 32'd1);
        check_val("wr_addr", s_address, 32'h0000_2000);
        check_val("wr_wstrb", 32'(s_wstrobe), 32'b0011);
        check_val("wr_wdata", s_wdata, 32'hAABB_CCDD);
        check_val("wr_wait_mready", 32'(m_ready), 32'd0);
        s_rdata_val = 32'h0000_0042;
        s_ready     = 1'b1;
        push(1, 32'h0000_0042);
        #1;
        check_val("wr_m0_ready", 32'(m_ready[0]), 32'd0);
        step();
        m_valid = '0;
        s_ready = 1'b0;

        // Timeout: master 2, slave never answers.
        m_address[2] = 32'h0000_0300;
        m_valid      = 3'b100;
        push(2, 32'hDEAD_BEEF);
        step();
        for (int b = 1; b <= 3; b++) begin
            #1;
            check_val("to_early_pulse", 32'(timeout), 32'd0);
            check_val("to_early_mready", 32'(m_ready), 32'd0);
            step();
        end
        #1;
        check_val("to_pulse", 32'(timeout), 32'd1);
        check_val("to_mready", 32'(m_ready), 32'b100);
        check_val("to_svalid", 32'(s_valid), 32'd1);
        step();
        m_valid = '0;
        #1;
        check_val("to_count", 32'(timeout_count), 32'd1);
        check_val("to_pulse_end", 32'(timeout), 32'd0);
        check_val("to_svalid_end", 32'(s_valid), 32'd0);
        step();
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_5555;
        #1;
        check_val("late_ready", 32'(m_ready), 32'd0);
        step();
        s_ready = 1'b0;
        #1;
        check_val("late_count", 32'(timeout_count), 32'd1);

        // Tie: s_ready arrives on the expiry cycle.
        m_address[0] = 32'h0000_0400;
        m_valid      = 3'b001;
        repeat (4) step();
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_7777;
        push(0, 32'h0000_7777);
        #1;
        check_val("tie_pulse", 32'(timeout), 32'd0);
        check_val("tie_mready", 32'(m_ready), 32'b001);
        step();
        m_valid = '0;
        s_ready = 1'b0;
        #1;
        check_val("tie_count", 32'(timeout_count), 32'd1);

        // Owner withdraws mid-transaction; master 2 asks meanwhile.
        m_address[1] = 32'h0000_0500;
        m_valid      = 3'b010;
        step();
        #1;
        check_val("drop_svalid_on", 32'(s_valid), 32'd1);
        m_valid = 3'b100;
        #1;
        check_val("drop_svalid_off", 32'(s_valid), 32'd0);
        check_val("drop_mready", 32'(m_ready), 32'd0);
        step();
        #1;
        check_val("drop_idle", 32'(s_valid), 32'd0);
        step();
        #1;
        check_val("drop_regrant", 32'(grant), 32'd2);
        check_val("drop_regrant_sv", 32'(s_valid), 32'd1);
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_9999;
        push(2, 32'h0000_9999);
        step();
        m_valid = '0;
        s_ready = 1'b0;

        // Reset in the middle of a transaction.
        m_address[0] = 32'h0000_0600;
        m_valid      = 3'b001;
        step();
        #1;
        check_val("mid_svalid", 32'(s_valid), 32'd1);
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_0BAD;
        reset       = 1'b0;
        #1;
        check_val("mid_rst_svalid", 32'(s_valid), 32'd0);
        check_val("mid_rst_mready", 32'(m_ready), 32'd0);
        check_val("mid_rst_count", 32'(timeout_count), 32'd0);
        step();
        s_ready = 1'b0;
        m_valid = 3'b011;
        reset   = 1'b1;
        #1;
        check_val("mid_rel_svalid", 32'(s_valid), 32'd0);
        step();
        #1;
        check_val("mid_rel_grant", 32'(grant), 32'd0);
        s_ready     = 1'b1;
        s_rdata_val = 32'h0000_1111;
        push(0, 32'h0000_1111);
        step();
        m_valid = '0;
        s_ready = 1'b0;

        // Interrupt broadcast.
        s_irq = 1'b1;
        #1;
        check_val("irq_on", 32'(m_irq), 32'b111);
        s_irq = 1'b0;
        #1;
        check_val("irq_off", 32'(m_irq), 32'd0);

        step();
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
